// File: rtl/iob_uart_poll_master.sv
// Configures an IOb UART, then polls it to move bytes between one-byte TX/RX holding registers and the UART.
// Bus fields are held until avalid & ready; each holding register deasserts its ready/valid while full or empty.
module iob_uart_poll_master #(
    parameter int          DATA_W         = 32,
    parameter int          ADDR_W         = 3,
    parameter logic [15:0] DIV            = 16'd434,
    parameter int          POLL_GAP       = 8,
    parameter int          SOFTRESET_ADDR = 0,
    parameter int          DIV_ADDR       = 2,
    parameter int          TXDATA_ADDR    = 4,
    parameter int          TXEN_ADDR      = 5,
    parameter int          RXEN_ADDR      = 6,
    parameter int          TXREADY_ADDR   = 0,
    parameter int          RXREADY_ADDR   = 1,
    parameter int          RXDATA_ADDR    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [7:0]            tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [7:0]            rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  init_done_o,
    output logic                  iob_avalid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic [DATA_W-1:0]     iob_rdata_i,
    input  logic                  iob_ready_i,
    input  logic                  iob_rvalid_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [3:0] {
        INIT_SRST1, INIT_SRST0, INIT_DIV, INIT_TXEN, INIT_RXEN,
        GAP, POLL_RX, READ_RX, POLL_TX, WRITE_TX
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_avalid;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_rd;
    logic                r_rd_wait;

    logic                r_tx_full;
    logic [7:0]          r_tx_data;
    logic                r_rx_full;
    logic [7:0]          r_rx_data;
    logic                r_toggle;
    logic                r_init_done;
    logic [GAP_W-1:0]    r_gap;

    logic                w_access;
    logic                w_rd;
    logic                w_div;
    logic [ADDR_W-1:0]   w_addr;
    logic [7:0]          w_byte;
    logic [DATA_W-1:0]   w_wdata;
    logic [STRB_W-1:0]   w_wstrb;
    logic                w_done;
    logic [7:0]          w_rbyte;
    logic                w_sel_rx;

    // An access completes on acceptance for writes, or on the first rvalid at/after acceptance for reads.
    assign w_done   = (r_avalid & iob_ready_i & (~r_rd | iob_rvalid_i)) | (r_rd_wait & iob_rvalid_i);
    assign w_rbyte  = iob_rdata_i[{r_addr[1:0], 3'b000} +: 8];
    assign w_sel_rx = ~r_rx_full & (~r_tx_full | ~r_toggle);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_state <= INIT_SRST1;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT_SRST1: if (w_done) w_next = INIT_SRST0;
            INIT_SRST0: if (w_done) w_next = INIT_DIV;
            INIT_DIV:   if (w_done) w_next = INIT_TXEN;
            INIT_TXEN:  if (w_done) w_next = INIT_RXEN;
            INIT_RXEN:  if (w_done) w_next = GAP;
            GAP: begin
                if (r_gap == '0) begin
                    if (w_sel_rx)       w_next = POLL_RX;
                    else if (r_tx_full) w_next = POLL_TX;
                end
            end
            POLL_RX:    if (w_done) w_next = w_rbyte[0] ? READ_RX : GAP;
            READ_RX:    if (w_done) w_next = GAP;
            POLL_TX:    if (w_done) w_next = w_rbyte[0] ? WRITE_TX : GAP;
            WRITE_TX:   if (w_done) w_next = GAP;
            default:    w_next = INIT_SRST1;
        endcase
    end

    always_comb begin
        w_access = 1'b1;
        w_rd     = 1'b0;
        w_div    = 1'b0;
        w_addr   = '0;
        w_byte   = 8'd0;
        case (r_state)
            INIT_SRST1: begin w_addr = ADDR_W'(SOFTRESET_ADDR); w_byte = 8'd1; end
            INIT_SRST0: begin w_addr = ADDR_W'(SOFTRESET_ADDR); w_byte = 8'd0; end
            INIT_DIV:   begin w_addr = ADDR_W'(DIV_ADDR);       w_div  = 1'b1; end
            INIT_TXEN:  begin w_addr = ADDR_W'(TXEN_ADDR);      w_byte = 8'd1; end
            INIT_RXEN:  begin w_addr = ADDR_W'(RXEN_ADDR);      w_byte = 8'd1; end
            POLL_RX:    begin w_addr = ADDR_W'(RXREADY_ADDR);   w_rd   = 1'b1; end
            READ_RX:    begin w_addr = ADDR_W'(RXDATA_ADDR);    w_rd   = 1'b1; end
            POLL_TX:    begin w_addr = ADDR_W'(TXREADY_ADDR);   w_rd   = 1'b1; end
            WRITE_TX:   begin w_addr = ADDR_W'(TXDATA_ADDR);    w_byte = r_tx_data; end
            default:    w_access = 1'b0;
        endcase
        w_wdata = '0;
        w_wstrb = '0;
        if (!w_rd) begin
            if (w_div) begin
                w_wdata = DATA_W'(DIV) << {w_addr[1:0], 3'b000};
                w_wstrb = STRB_W'(2'b11) << w_addr[1:0];
            end else begin
                w_wdata = DATA_W'(w_byte) << {w_addr[1:0], 3'b000};
                w_wstrb = STRB_W'(1) << w_addr[1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_avalid    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rd        <= 1'b0;
            r_rd_wait   <= 1'b0;
            r_tx_full   <= 1'b0;
            r_tx_data   <= 8'd0;
            r_rx_full   <= 1'b0;
            r_rx_data   <= 8'd0;
            r_toggle    <= 1'b0;
            r_init_done <= 1'b0;
            r_gap       <= '0;
        end else begin
            // A new access is only launched once the previous one has fully completed.
            if (r_avalid) begin
                if (iob_ready_i) begin
                    r_avalid <= 1'b0;
                    if (r_rd && !iob_rvalid_i) r_rd_wait <= 1'b1;
                end
            end else if (r_rd_wait) begin
                if (iob_rvalid_i) r_rd_wait <= 1'b0;
            end else if (w_access) begin
                r_avalid <= 1'b1;
                r_addr   <= w_addr;
                r_wdata  <= w_wdata;
                r_wstrb  <= w_wstrb;
                r_rd     <= w_rd;
            end

            if (w_next == GAP && (r_state != GAP || r_gap == '0)) r_gap <= GAP_W'(POLL_GAP - 1);
            else if (r_state == GAP && r_gap != '0)                r_gap <= r_gap - 1'b1;

            if (r_state == GAP && w_next == POLL_RX) r_toggle <= 1'b1;
            if (r_state == GAP && w_next == POLL_TX) r_toggle <= 1'b0;

            if (r_state == INIT_RXEN && w_done) r_init_done <= 1'b1;

            if (r_state == WRITE_TX && w_done) begin
                r_tx_full <= 1'b0;
            end else if (tx_valid_i && tx_ready_o) begin
                r_tx_full <= 1'b1;
                r_tx_data <= tx_data_i;
            end

            if (r_state == READ_RX && w_done) begin
                r_rx_full <= 1'b1;
                r_rx_data <= w_rbyte;
            end else if (r_rx_full && rx_ready_i) begin
                r_rx_full <= 1'b0;
            end
        end
    end

    assign tx_ready_o   = r_init_done & ~r_tx_full;
    assign rx_valid_o   = r_rx_full;
    assign rx_data_o    = r_rx_data;
    assign init_done_o  = r_init_done;
    assign iob_avalid_o = r_avalid;
    assign iob_addr_o   = r_addr;
    assign iob_wdata_o  = r_wdata;
    assign iob_wstrb_o  = r_wstrb;

endmodule

// File: tb/tb_iob_uart_poll_master.sv
// Directed bench for iob_uart_poll_master with a behavioural IOb UART responder.
module tb_iob_uart_poll_master;
    localparam int POLL_GAP = 8;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [7:0]  tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        init_done_o;
    logic        iob_avalid_o;
    logic [2:0]  iob_addr_o;
    logic [31:0] iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic [31:0] iob_rdata_i = '0;
    logic        iob_ready_i = 1'b0;
    logic        iob_rvalid_i = 1'b0;

    always #5 clk_i = ~clk_i;

    iob_uart_poll_master #(.POLL_GAP(POLL_GAP)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .init_done_o(init_done_o),
        .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
        .iob_wstrb_o(iob_wstrb_o), .iob_rdata_i(iob_rdata_i), .iob_ready_i(iob_ready_i),
        .iob_rvalid_i(iob_rvalid_i)
    );

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          hold;
        bit          stable;
        int          cyc;
        logic        txrdy;
    } acc_t;

    acc_t        log_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ready_delay = 0;
    int          wr_delay = 0;
    int          tx_polls_seen = 0;
    int          tx_ready_after = 1000000;
    logic        rx_rdy = 1'b0;
    logic [31:0] rx_rdata = '0;

    int          hold = 0;
    bit          stable = 1'b1;
    logic [2:0]  f_addr;
    logic [31:0] f_wdata;
    logic [3:0]  f_wstrb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic acc_t at(input int i);
        acc_t e;
        e.addr = '0; e.wdata = '0; e.wstrb = '0; e.hold = 0; e.stable = 1'b0; e.cyc = 0; e.txrdy = 1'b0;
        if (i >= 0 && i < log_q.size()) e = log_q[i];
        return e;
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // UART responder: ready after a programmable number of avalid cycles, rvalid with ready on reads.
    always @(negedge clk_i) begin
        int   dly;
        acc_t e;
        if (iob_avalid_o) begin
            if (hold == 0) begin
                f_addr = iob_addr_o; f_wdata = iob_wdata_o; f_wstrb = iob_wstrb_o; stable = 1'b1;
            end else if (iob_addr_o !== f_addr || iob_wdata_o !== f_wdata || iob_wstrb_o !== f_wstrb) begin
                stable = 1'b0;
            end
            hold++;
            dly = (iob_wstrb_o != 4'd0 && iob_addr_o == 3'd4) ? wr_delay : ready_delay;
            if (hold > dly) begin
                iob_ready_i  = 1'b1;
                iob_rvalid_i = (iob_wstrb_o == 4'd0);
                iob_rdata_i  = '0;
                if (iob_wstrb_o == 4'd0) begin
                    if (iob_addr_o == 3'd0) begin
                        iob_rdata_i = (tx_polls_seen >= tx_ready_after) ? 32'd1 : 32'd0;
                        tx_polls_seen++;
                    end else if (iob_addr_o == 3'd1) begin
                        iob_rdata_i = {23'd0, rx_rdy, 8'd0};
                    end else if (iob_addr_o == 3'd4) begin
                        iob_rdata_i = rx_rdata;
                    end
                end
                e.addr = iob_addr_o; e.wdata = iob_wdata_o; e.wstrb = iob_wstrb_o;
                e.hold = hold; e.stable = stable; e.cyc = cyc; e.txrdy = tx_ready_o;
                log_q.push_back(e);
                hold = 0;
            end else begin
                iob_ready_i  = 1'b0;
                iob_rvalid_i = 1'b0;
            end
        end else begin
            iob_ready_i  = 1'b0;
            iob_rvalid_i = 1'b0;
            hold = 0;
        end
    end

    task automatic wait_init(input string tag);
        int n = 0;
        while (!init_done_o && n < 3000) begin @(negedge clk_i); n++; end
        chk(tag, init_done_o, 1'b1);
    endtask

    task automatic wait_log(input int n, input string tag);
        int k = 0;
        while (log_q.size() < n && k < 3000) begin @(negedge clk_i); k++; end
        chk(tag, log_q.size() >= n, 1'b1);
    endtask

    task automatic wait_rx_valid(input string tag);
        int k = 0;
        while (!rx_valid_o && k < 3000) begin @(negedge clk_i); k++; end
        chk(tag, rx_valid_o, 1'b1);
    endtask

    function automatic int find_write(input int from);
        for (int i = from; i < log_q.size(); i++)
            if (log_q[i].wstrb != 4'd0) return i;
        return -1;
    endfunction

    initial begin
        logic [2:0]  exp_addr [5];
        logic [31:0] exp_wdata[5];
        logic [3:0]  exp_wstrb[5];
        int base, cnt, widx, t0, k;
        acc_t e1, e2, e3;

        exp_addr  = '{3'd0, 3'd0, 3'd2, 3'd5, 3'd6};
        exp_wdata = '{32'd1, 32'd0, 32'd434 << 16, 32'd1 << 8, 32'd1 << 16};
        exp_wstrb = '{4'b0001, 4'b0001, 4'b1100, 4'b0010, 4'b0100};

        rst_n_i = 1'b0; tx_valid_i = 1'b0; tx_data_i = 8'd0; rx_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_avalid", iob_avalid_o, 0);
        chk("rst_addr", iob_addr_o, 0);
        chk("rst_wdata", iob_wdata_o, 0);
        chk("rst_wstrb", iob_wstrb_o, 0);
        chk("rst_tx_ready", tx_ready_o, 0);
        chk("rst_rx_valid", rx_valid_o, 0);
        chk("rst_rx_data", rx_data_o, 0);
        chk("rst_init_done", init_done_o, 0);

        // Init sequence with an always-ready UART.
        base = log_q.size();
        rst_n_i = 1'b1;
        wait_init("init_done");
        chk("init_tx_ready", tx_ready_o, 1);
        wait_log(base + 6, "first_poll_seen");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("init%0d_addr", i), at(base + i).addr, exp_addr[i]);
            chk($sformatf("init%0d_wdata", i), at(base + i).wdata, exp_wdata[i]);
            chk($sformatf("init%0d_wstrb", i), at(base + i).wstrb, exp_wstrb[i]);
        end
        chk("poll_rx_addr", at(base + 5).addr, 3'd1);
        chk("poll_rx_wstrb", at(base + 5).wstrb, 4'd0);
        // GAP cycles plus one launch cycle plus one handshake cycle between acceptances.
        chk("poll_gap", at(base + 5).cyc - at(base + 4).cyc, POLL_GAP + 2);

        // Slow UART during init: held fields, one DIV write.
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        ready_delay = 3;
        base = log_q.size();
        rst_n_i = 1'b1;
        wait_init("init_done_slow");
        ready_delay = 0;
        cnt = 0; t0 = -1;
        for (int i = base; i < log_q.size(); i++)
            if (log_q[i].addr == 3'd2 && log_q[i].wstrb == 4'b1100) begin cnt++; t0 = i; end
        chk("div_single", cnt, 1);
        chk("div_hold", at(t0).hold, 4);
        chk("div_stable", at(t0).stable, 1);

        // TX path: TXREADY 0,0,1 then the data write.
        tx_ready_after = tx_polls_seen + 2;
        base = log_q.size();
        tx_data_i = 8'hA5; tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        chk("tx_ready_full", tx_ready_o, 0);
        k = 0;
        while (find_write(base) < 0 && k < 3000) begin @(negedge clk_i); k++; end
        widx = find_write(base);
        chk("tx_write_seen", widx >= 0, 1);
        cnt = 0; t0 = -1;
        for (int i = base; i < widx; i++)
            if (log_q[i].addr == 3'd0 && log_q[i].wstrb == 4'd0) begin
                if (t0 < 0) t0 = i;
                cnt++;
            end
        chk("tx_poll_count", cnt, 3);
        chk("tx_poll_gap", at(t0 + 1).cyc - at(t0).cyc, POLL_GAP + 2);
        chk("tx_wr_addr", at(widx).addr, 3'd4);
        chk("tx_wr_wdata", at(widx).wdata, 32'h0000_00A5);
        chk("tx_wr_wstrb", at(widx).wstrb, 4'b0001);
        chk("tx_ready_during_wr", at(widx).txrdy, 0);
        @(negedge clk_i);
        chk("tx_ready_after_wr", tx_ready_o, 1);

        // RX path: lane extraction, hold while not consumed, second byte.
        rx_rdy = 1'b1; rx_rdata = 32'h0000_3C00;
        wait_rx_valid("rx_valid1");
        chk("rx_data_lane0", rx_data_o, 8'h00);
        base = log_q.size();
        rx_rdata = 32'h0000_005A;
        repeat (40) @(negedge clk_i);
        chk("rx_no_polls_when_full", log_q.size() - base, 0);
        chk("rx_data_stable", rx_data_o, 8'h00);
        chk("rx_valid_held", rx_valid_o, 1);
        rx_ready_i = 1'b1;
        @(negedge clk_i);
        rx_ready_i = 1'b0;
        chk("rx_pop1", rx_valid_o, 0);
        wait_rx_valid("rx_valid2");
        chk("rx_data_5a", rx_data_o, 8'h5A);

        // Both directions pending: polls must alternate.
        rx_rdy = 1'b0;
        rx_ready_i = 1'b1;
        @(negedge clk_i);
        rx_ready_i = 1'b0;
        chk("rx_pop2", rx_valid_o, 0);
        tx_ready_after = tx_polls_seen + 100000;
        tx_data_i = 8'h3C; tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        base = log_q.size();
        wait_log(base + 4, "alt_polls_seen");
        e1 = at(base + 1); e2 = at(base + 2); e3 = at(base + 3);
        chk("alt_12_differ", e1.addr ^ e2.addr, 1);
        chk("alt_12_set", e1.addr + e2.addr, 1);
        chk("alt_13_same", e3.addr, e1.addr);
        chk("alt_reads", {e1.wstrb, e2.wstrb, e3.wstrb}, 0);

        // Reset in the middle of a stalled TXDATA write.
        wr_delay = 100000;
        tx_ready_after = tx_polls_seen;
        k = 0;
        while (!(iob_avalid_o && iob_addr_o == 3'd4 && iob_wstrb_o != 4'd0) && k < 3000) begin
            @(negedge clk_i); k++;
        end
        chk("wr_pending_seen", iob_avalid_o, 1);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_avalid", iob_avalid_o, 0);
        chk("mid_rst_wstrb", iob_wstrb_o, 0);
        chk("mid_rst_tx_ready", tx_ready_o, 0);
        chk("mid_rst_init_done", init_done_o, 0);
        chk("mid_rst_rx_valid", rx_valid_o, 0);
        wr_delay = 0;
        base = log_q.size();
        rst_n_i = 1'b1;
        wait_init("reinit_done");
        chk("reinit_addr", at(base).addr, 3'd0);
        chk("reinit_wdata", at(base).wdata, 32'd1);
        chk("reinit_wstrb", at(base).wstrb, 4'b0001);
        chk("reinit_tx_empty", tx_ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
